// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares the single-port data memory between the core load/store
//            path (port C) and a DMA/loader engine (port D). Round-robin
//            arbitration with a bounded burst length while contended, a
//            one-beat-per-cycle handshake, and a combinational core stall.
// Ports    : clk, reset (async, active-low)
//            c_req/c_we/c_adr/c_wd -> c_ack/c_rd/c_stall   core port
//            d_req/d_we/d_adr/d_wd -> d_ack/d_rd           DMA port
//            mem_we/mem_adr/mem_wd -> dmem, mem_rd <- dmem (async read)
// Options  : DMEM_ARB_STATS_EN adds stats_clr input and c_beats, d_beats,
//            conflict_cycles saturating 16-bit counters.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_BURST  = 4,
  parameter int CORE_FIRST = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_adr,
  input  logic [DW-1:0] c_wd,
  output logic          c_ack,
  output logic [DW-1:0] c_rd,
  output logic          c_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_adr,
  input  logic [DW-1:0] d_wd,
  output logic          d_ack,
  output logic [DW-1:0] d_rd,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
`ifdef DMEM_ARB_STATS_EN
  input  logic          stats_clr,
  output logic [15:0]   c_beats,
  output logic [15:0]   d_beats,
  output logic [15:0]   conflict_cycles,
`endif
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_C = 2'd1,
    ST_GNT_D = 2'd2
  } state_t;

  localparam logic [3:0] c_max_burst = 4'(MAX_BURST);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_burst_cnt;
  logic [3:0] w_burst_cnt_nxt;
  logic [3:0] w_burst_inc;
  logic       w_burst_limit;

  // Saturating beat count for the current owner.
  assign w_burst_inc = (r_burst_cnt >= c_max_burst) ? r_burst_cnt : r_burst_cnt + 4'd1;

  // True when the beat in progress is the last one allowed under contention.
  assign w_burst_limit = ({1'b0, r_burst_cnt} + 5'd1) >= {1'b0, c_max_burst};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_burst_cnt <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_burst_cnt_nxt = r_burst_cnt;
    c_ack           = 1'b0;
    d_ack           = 1'b0;
    c_rd            = '0;
    d_rd            = '0;
    mem_we          = 1'b0;
    mem_adr         = '0;
    mem_wd          = '0;

    case (r_state)
      ST_IDLE: begin
        w_burst_cnt_nxt = 4'd0;
        if (c_req && d_req) begin
          w_state_nxt = (CORE_FIRST != 0) ? ST_GNT_C : ST_GNT_D;
        end else if (c_req) begin
          w_state_nxt = ST_GNT_C;
        end else if (d_req) begin
          w_state_nxt = ST_GNT_D;
        end
      end

      ST_GNT_C: begin
        mem_adr = c_adr;
        mem_wd  = c_wd;
        mem_we  = c_we & c_req;
        c_ack   = c_req;
        c_rd    = mem_rd;
        if (c_req) begin
          w_burst_cnt_nxt = w_burst_inc;
        end
        // Hand over directly (no idle bubble) when the burst budget is used
        // up or the owner has let go while the other side waits.
        if (d_req && (w_burst_limit || !c_req)) begin
          w_state_nxt     = ST_GNT_D;
          w_burst_cnt_nxt = 4'd0;
        end else if (!c_req) begin
          w_state_nxt     = ST_IDLE;
          w_burst_cnt_nxt = 4'd0;
        end
      end

      ST_GNT_D: begin
        mem_adr = d_adr;
        mem_wd  = d_wd;
        mem_we  = d_we & d_req;
        d_ack   = d_req;
        d_rd    = mem_rd;
        if (d_req) begin
          w_burst_cnt_nxt = w_burst_inc;
        end
        if (c_req && (w_burst_limit || !d_req)) begin
          w_state_nxt     = ST_GNT_C;
          w_burst_cnt_nxt = 4'd0;
        end else if (!d_req) begin
          w_state_nxt     = ST_IDLE;
          w_burst_cnt_nxt = 4'd0;
        end
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_burst_cnt_nxt = 4'd0;
      end
    endcase
  end

  // Combinational so the core can hold its PC in the same cycle.
  assign c_stall = c_req & ~c_ack;

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_beats         <= 16'd0;
      d_beats         <= 16'd0;
      conflict_cycles <= 16'd0;
    end else if (stats_clr) begin
      c_beats         <= 16'd0;
      d_beats         <= 16'd0;
      conflict_cycles <= 16'd0;
    end else begin
      if (c_ack && (c_beats != 16'hFFFF)) begin
        c_beats <= c_beats + 16'd1;
      end
      if (d_ack && (d_beats != 16'hFFFF)) begin
        d_beats <= d_beats + 16'd1;
      end
      if (c_req && d_req && (conflict_cycles != 16'hFFFF)) begin
        conflict_cycles <= conflict_cycles + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter. A bench memory answers
//            mem_rd; an owner/tenure model predicts every output each cycle,
//            and directed sequences pin key cycles with literal values.
//            A second instance with CORE_FIRST=0 shares the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] c_adr = '0, d_adr = '0;
  logic [DW-1:0] c_wd = '0, d_wd = '0;
  logic          c_ack, c_stall, d_ack, mem_we;
  logic [DW-1:0] c_rd, d_rd, mem_wd, mem_rd;
  logic [AW-1:0] mem_adr;

  logic          c_ack0, c_stall0, d_ack0, mem_we0;
  logic [DW-1:0] c_rd0, d_rd0, mem_wd0, mem_rd0;
  logic [AW-1:0] mem_adr0;

`ifdef DMEM_ARB_STATS_EN
  logic          stats_clr = 1'b0;
  logic [15:0]   c_beats, d_beats, conflict_cycles;
  logic [15:0]   c_beats0, d_beats0, conflict_cycles0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB), .CORE_FIRST(1)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wd(c_wd),
    .c_ack(c_ack), .c_rd(c_rd), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wd(d_wd),
    .d_ack(d_ack), .d_rd(d_rd),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd),
`ifdef DMEM_ARB_STATS_EN
    .stats_clr(stats_clr), .c_beats(c_beats), .d_beats(d_beats),
    .conflict_cycles(conflict_cycles),
`endif
    .mem_rd(mem_rd)
  );

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB), .CORE_FIRST(0)) dut0 (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wd(c_wd),
    .c_ack(c_ack0), .c_rd(c_rd0), .c_stall(c_stall0),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wd(d_wd),
    .d_ack(d_ack0), .d_rd(d_rd0),
    .mem_we(mem_we0), .mem_adr(mem_adr0), .mem_wd(mem_wd0),
`ifdef DMEM_ARB_STATS_EN
    .stats_clr(stats_clr), .c_beats(c_beats0), .d_beats(d_beats0),
    .conflict_cycles(conflict_cycles0),
`endif
    .mem_rd(mem_rd0)
  );

  // Bench data memory: asynchronous read, write on the accepting edge.
  logic [31:0] mem [0:255];
  assign mem_rd  = mem[mem_adr[9:2]];
  assign mem_rd0 = 32'h0;
  always @(posedge clk) begin
    if (mem_we) mem[mem_adr[9:2]] <= mem_wd;
  end

  // ---------------------------------------------------------------------
  // Model: who owns the memory (0 none, 1 core, 2 DMA) and how many beats
  // the owner has been served in its current tenure.
  // ---------------------------------------------------------------------
  int   m_owner  = 0;
  int   m_tenure = 0;
  logic own_req, oth_req;
  int   served;
  assign own_req = (m_owner == 1) ? c_req : d_req;
  assign oth_req = (m_owner == 1) ? d_req : c_req;
  assign served  = m_tenure + (own_req ? 1 : 0);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner  <= 0;
      m_tenure <= 0;
    end else if (m_owner == 0) begin
      m_tenure <= 0;
      if (c_req && d_req) m_owner <= 1;
      else if (c_req)     m_owner <= 1;
      else if (d_req)     m_owner <= 2;
    end else if (oth_req && (served >= MB || !own_req)) begin
      m_owner  <= 3 - m_owner;
      m_tenure <= 0;
    end else if (own_req) begin
      m_tenure <= served;
    end else begin
      m_owner  <= 0;
      m_tenure <= 0;
    end
  end

  function automatic logic [131:0] model_out();
    logic        eca, eda, ewe;
    logic [31:0] eadr, ewd, data;
    eca  = (m_owner == 1) && c_req;
    eda  = (m_owner == 2) && d_req;
    eadr = (m_owner == 1) ? c_adr : (m_owner == 2) ? d_adr : 32'h0;
    ewd  = (m_owner == 1) ? c_wd  : (m_owner == 2) ? d_wd  : 32'h0;
    ewe  = (m_owner == 1) ? (c_we & c_req) : (m_owner == 2) ? (d_we & d_req) : 1'b0;
    data = mem[eadr[9:2]];
    return {eca, eda, c_req & ~eca, ewe, eadr, ewd,
            (m_owner == 1) ? data : 32'h0, (m_owner == 2) ? data : 32'h0};
  endfunction

  task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model", {c_ack, d_ack, c_stall, mem_we, mem_adr, mem_wd, c_rd, d_rd}, model_out());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef DMEM_ARB_STATS_EN
  int acks_seen;
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {c_ack, d_ack, mem_we, d_ack0}, 4'b0000);
    #2 reset = 1'b1;
    tick();

    // Core-only read from 0x10
    c_req = 1'b1; c_we = 1'b0; c_adr = 32'h10;
    #1 chk("core_arb_cycle", {c_ack, c_stall}, 2'b01);
    tick();
    #1 chk("core_beat1", {c_ack, c_stall, mem_we, c_rd}, {3'b100, 32'hDEADBEEF});
    tick();
    #1 chk("core_beat2", {c_ack, mem_we, c_rd}, {2'b10, 32'hDEADBEEF});
    tick();
    c_req = 1'b0;
    tick();

    // Uncontested DMA write burst: 8 beats, 0x100.., data 0..7
    d_req = 1'b1; d_we = 1'b1; d_adr = 32'h100; d_wd = 32'd0;
    #1 chk("dma_arb_cycle", {1'b0, d_ack}, 2'b00);
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        d_adr = 32'h100 + 32'(4 * i);
        d_wd  = 32'(i);
      end
      #1 chk("dma_beat", {d_ack, mem_we, mem_adr}, {2'b11, 32'h100 + 32'(4 * i)});
      tick();
    end
    d_req = 1'b0; d_we = 1'b0;
    tick();

    // Core reads back a DMA-written word
    c_req = 1'b1; c_adr = 32'h108;
    tick();
    #1 chk("readback_0x108", {c_ack, c_rd}, {1'b1, 32'd2});
    tick();
    c_req = 1'b0;
    tick();

    // Continuous contention: C x4, D x4, C x4, D x4, no idle cycle
    c_req = 1'b1; d_req = 1'b1; c_adr = 32'h10; d_adr = 32'h104;
    #1 chk("contend_arb_cycle", {c_ack, d_ack, c_stall}, 3'b001);
    tick();
    for (int i = 0; i < 16; i++) begin
      logic exp_c;
      exp_c = ((i / 4) % 2) == 0;
      #1 chk("contend_pattern", {c_ack, d_ack, c_stall}, {exp_c, ~exp_c, ~exp_c});
      if (i == 0) chk("core_first0_dma_wins", {c_ack0, d_ack0}, 2'b01);
      tick();
    end
    c_req = 1'b0; d_req = 1'b0;
    tick();
    tick();

    // Long uncontested DMA burst, then core arrives: yield after that beat
    d_req = 1'b1; d_we = 1'b1; d_adr = 32'h200; d_wd = 32'hAA;
    tick();
    repeat (6) tick();
    c_req = 1'b1; c_we = 1'b0; c_adr = 32'h10;
    #1 chk("late_core_waits", {d_ack, c_stall}, 2'b11);
    tick();
    #1 chk("late_core_granted", {c_ack, d_ack}, 2'b10);
    tick();
    // Core drops its request with a write pending and DMA waiting
    c_req = 1'b0; c_we = 1'b1;
    #1 chk("dropped_req_no_write", {c_ack, mem_we}, 2'b00);
    tick();
    #1 chk("handover_on_drop", {c_ack, d_ack}, 2'b01);
    c_we = 1'b0; d_req = 1'b0;
    tick();
    tick();

    // Reset pulse at beat 2 of a DMA burst
    d_req = 1'b1; d_we = 1'b1; d_adr = 32'h300; d_wd = 32'h55;
    tick();
    tick();
    tick();
    #1 chk("dma_beat2_before_reset", {d_ack, mem_we}, 2'b11);
    #1 reset = 1'b0;
    #1 chk("reset_mid_burst", {d_ack, mem_we}, 2'b00);
    d_req = 1'b0; d_we = 1'b0; c_req = 1'b1; c_adr = 32'h10;
    @(posedge clk);
    #3 reset = 1'b1;
    #1 chk("post_reset_idle", {c_ack, c_stall}, 2'b01);
    @(posedge clk);
    #1 chk("post_reset_core_ack", c_ack, 1'b1);
    c_req = 1'b0;
    tick();
    tick();

`ifdef DMEM_ARB_STATS_EN
    // Ten contention cycles after a clear
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    c_req = 1'b1; d_req = 1'b1;
    acks_seen = 0;
    for (int i = 0; i < 10; i++) begin
      #1 if (c_ack || d_ack) acks_seen++;
      tick();
    end
    c_req = 1'b0; d_req = 1'b0;
    #1 chk("stats_conflicts", conflict_cycles, 16'd10);
    chk("stats_beats_total", 32'(c_beats) + 32'(d_beats), 32'(acks_seen));
    chk("stats_split", {c_beats, d_beats}, {16'd5, 16'd4});
    tick();
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    #1 chk("stats_cleared", {c_beats, d_beats, conflict_cycles}, 48'h0);
    tick();
`endif

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
